cavlc_bit_packer: RTL and testbench
===================================

// Module: cavlc_bit_packer
// PURPOSE
//  Downstream of RunBefore and the other CAVLC code generators. Packs right-aligned variable-length
//  codes (up to 25 bits, MSB of the code sent first) into 32-bit output words with valid/ready flow
//  control. On flush it zero-pads the final partial word and reports how many of its bytes are valid.
// PARAMETERS
//  WORD_W  32  output word width; only 32 is verified
//  CODE_W  25  max code length; matches RunBefore CodeBit
//  LEN_W    5  width of the code-length field
// PORTS
//  clk         in   1       clock; all state updates on posedge
//  rst         in   1       asynchronous active-low reset
//  in_valid    in   1       code present on in_bits/in_len (RunBefore finish)
//  in_ready    out  1       packer can accept a code or a flush this cycle
//  in_bits     in   CODE_W  code, right-aligned; bits above in_len are ignored
//  in_len      in   LEN_W   code length 0..25; values >25 are treated as 25
//  flush       in   1       end of block: emit the remaining bits
//  out_valid   out  1       out_data holds a word
//  out_ready   in   1       consumer takes the word when out_valid & out_ready
//  out_data    out  WORD_W  packed bits; first bit is in bit 31
//  out_last    out  1       word is the final, padded word of a flush
//  out_nbytes  out  3       valid bytes in out_data: 4 for full words, 1..4 for the last word
//  flush_done  out  1       one-cycle pulse when a flush completes
// BEHAVIOUR
//  Reset (rst=0, asynchronous): acc=0, cnt=0, state=RUN.
//   Outputs during reset: out_valid=0, out_data=0, out_last=0, out_nbytes=0, flush_done=0, in_ready=0.
//  State: acc[63:0], MSB-aligned pending bits; cnt[6:0], number of pending bits (0..56).
//  in_ready = rst & (state==RUN) & (cnt<32). It is combinational and does not depend on in_valid.
//  Accept, when in_valid & in_ready:
//   - Mask in_bits to its low L bits.
//   - Place them at acc[63-cnt -: L], MSB first.
//   - cnt += L.
//   - L=0 is accepted and changes nothing.
//  Drain, when cnt>=32 & (!out_valid | out_ready):
//   - out_data <= acc[63:32]; acc <<= 32; cnt -= 32.
//   - out_valid <= 1; out_nbytes <= 4; out_last <= 0.
//  Accept and drain never occur in the same cycle, because accept needs cnt<32 and drain needs cnt>=32.
//  Output handshake:
//   - When out_valid & out_ready and no new load: out_valid <= 0.
//   - A load and a consume in the same cycle is legal and replaces the word.
//   - out_data, out_last and out_nbytes are stable while out_valid & !out_ready.
//  Latency: if an accept at edge N raises cnt to >=32, that word is visible after edge N+1
//   (given a free output slot). Worst-case throughput is 1 code/cycle plus 1 drain cycle per word.
//  Flush:
//   - Sampled when flush & in_ready. If in_valid is also high, the code is appended first.
//   - Next state is FLUSH; in_ready=0 while in FLUSH.
//  FLUSH state:
//   - If cnt>=32, drain normally.
//   - When cnt<32 and the output slot is free (!out_valid | out_ready):
//      - cnt>0: out_data <= {acc[63:32] with bits below cnt zeroed}, out_last <= 1,
//        out_nbytes <= ceil(cnt/8), out_valid <= 1; then cnt=0, acc=0.
//      - cnt=0: no word is emitted.
//     In both cases flush_done pulses that cycle and the state returns to RUN.
//  flush while in FLUSH is not observable, because in_ready=0.
//  Reset mid-operation drops all pending bits and any held output word. No partial word is emitted.
//  State machine: RUN -(flush accepted)-> FLUSH -(final load or cnt==0, slot free)-> RUN.
// TESTING
//  T1: out_ready=1; code 0x7EE6/len15 (111111011100110), then 0x1FFFF/len17.
//      -> one word 0xFDCDFFFF, out_nbytes=4, out_last=0, cnt=0.
//  T2: code 0b00/len2, then flush.
//      -> out_data=0x00000000, out_nbytes=1, out_last=1, flush_done pulses with the load.
//  T3: out_ready=0; three codes 0x1FFFFFF/len25.
//      -> words 1 and 2 accepted; word 0xFFFFFFFF is loaded (cnt=18); code 3 accepted (cnt=43).
//      -> in_ready=0 and out_data holds until out_ready=1; then the next word is 0xFFFFFFFF and cnt=11.
//  T4: flush with cnt=0.
//      -> flush_done pulses after 1 cycle in FLUSH, out_valid stays 0.
//      -> code 0x5/len3 followed by len0 gives cnt=3; flush -> out_data=0xA0000000, out_nbytes=1.
//  T5: accumulate 20 bits with out_valid=1 held (out_ready=0); assert rst asynchronously between edges.
//      -> all outputs drop to 0 immediately. After release, in_ready=1 and the next flush emits nothing.
//  T6: in_len=31 with in_bits=0x1FFFFFF.
//      -> treated as len25, cnt += 25. Then a flush gives out_nbytes=4 and last word 0xFFFFFF80.

Source files
------------

// File: rtl/cavlc_bit_packer.sv
// Packs right-aligned variable-length codes (MSB first) into 32-bit words with valid/ready flow control.
// A flush zero-pads the trailing partial word and reports its valid byte count.
module cavlc_bit_packer #(
  parameter int WORD_W = 32,
  parameter int CODE_W = 25,
  parameter int LEN_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_bits,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic [2:0]        out_nbytes,
  output logic              flush_done
);

  localparam int ACC_W = 2 * WORD_W;

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ACC_W-1:0]    r_acc;
  logic [6:0]          r_cnt;
  logic [WORD_W-1:0]   r_out_data;
  logic                r_out_valid;
  logic                r_out_last;
  logic [2:0]          r_out_nbytes;
  logic                r_flush_done;

  logic                w_in_ready;
  logic                w_slot_free;
  logic                w_accept;
  logic                w_flush_acc;
  logic                w_drain;
  logic                w_final;
  logic [LEN_W-1:0]    w_len;
  logic [CODE_W-1:0]   w_code_masked;
  logic [ACC_W-1:0]    w_code_top;
  logic [6:0]          w_shl;
  logic [ACC_W-1:0]    w_code_pos;
  logic [WORD_W-1:0]   w_keep;
  logic [2:0]          w_nbytes;

  always_comb begin
    w_len         = (in_len > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : in_len;
    w_code_masked = in_bits & ~({CODE_W{1'b1}} << w_len);
    // MSB-align the code in the accumulator, then slide it down past the pending bits
    w_code_top    = {w_code_masked, {(ACC_W-CODE_W){1'b0}}};
    w_shl         = 7'(CODE_W) - 7'(w_len);
    w_code_pos    = (w_code_top << w_shl) >> r_cnt;
    w_keep        = ~({WORD_W{1'b1}} >> r_cnt);
    w_nbytes      = 3'((r_cnt + 7'd7) >> 3);
  end

  always_comb begin
    w_in_ready  = rst & (r_state == S_RUN) & (r_cnt < 7'(WORD_W));
    w_slot_free = ~r_out_valid | out_ready;
    w_accept    = in_valid & w_in_ready;
    w_flush_acc = flush & w_in_ready;
    w_drain     = (r_cnt >= 7'(WORD_W)) & w_slot_free;
    w_final     = (r_state == S_FLUSH) & (r_cnt < 7'(WORD_W)) & w_slot_free;
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (w_flush_acc) w_state_nxt = S_FLUSH;
      S_FLUSH: if (w_final)     w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_nbytes <= '0;
      r_flush_done <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc <= r_acc | w_code_pos;
        r_cnt <= r_cnt + 7'(w_len);
      end else if (w_drain) begin
        r_acc <= r_acc << WORD_W;
        r_cnt <= r_cnt - 7'(WORD_W);
      end else if (w_final) begin
        r_acc <= '0;
        r_cnt <= '0;
      end

      if (w_drain) begin
        r_out_data   <= r_acc[ACC_W-1 -: WORD_W];
        r_out_valid  <= 1'b1;
        r_out_last   <= 1'b0;
        r_out_nbytes <= 3'd4;
      end else if (w_final && (r_cnt != 7'd0)) begin
        r_out_data   <= r_acc[ACC_W-1 -: WORD_W] & w_keep;
        r_out_valid  <= 1'b1;
        r_out_last   <= 1'b1;
        r_out_nbytes <= w_nbytes;
      end else if (out_ready) begin
        r_out_valid  <= 1'b0;
      end

      r_flush_done <= w_final;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;
  assign out_nbytes = r_out_nbytes;
  assign flush_done = r_flush_done;

endmodule

// File: tb/tb_cavlc_bit_packer.sv
// Scoreboard bench for cavlc_bit_packer: a bit-queue reference model predicts every output word,
// an independent monitor pops and compares on each out_valid & out_ready.
module tb_cavlc_bit_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] in_bits;
  logic [4:0]  in_len;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [2:0]  out_nbytes;
  logic        flush_done;

  cavlc_bit_packer #(.WORD_W(32), .CODE_W(25), .LEN_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bits    (in_bits),
    .in_len     (in_len),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_nbytes (out_nbytes),
    .flush_done (flush_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic [2:0]  nb;
  } exp_t;

  exp_t expq[$];
  bit   bitq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_flushes = 0;
  int   got_flushes = 0;
  int   rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Reference model: a plain FIFO of bits, cut into 32-bit words
  task automatic model(input bit v, input logic [24:0] b, input logic [4:0] l, input bit f);
    int L;
    int n;
    exp_t e;
    logic [24:0] bb;
    bb = b;
    if (v) begin
      L = (l > 5'd25) ? 25 : int'(l);
      for (int i = L - 1; i >= 0; i--) bitq.push_back(bb[i]);
    end
    while (bitq.size() >= 32) begin
      e.d = '0;
      for (int i = 31; i >= 0; i--) e.d[i] = bitq.pop_front();
      e.l = 1'b0;
      e.nb = 3'd4;
      expq.push_back(e);
    end
    if (f) begin
      exp_flushes++;
      if (bitq.size() > 0) begin
        n = bitq.size();
        e.d = '0;
        for (int i = 0; i < n; i++) e.d[31-i] = bitq.pop_front();
        e.l = 1'b1;
        e.nb = 3'((n + 7) / 8);
        expq.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_tests++;
      if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got data=%h last=%0b nbytes=%0d, required no word",
                 out_data, out_last, out_nbytes);
      end else begin
        e = expq.pop_front();
        if (out_data !== e.d || out_last !== e.l || out_nbytes !== e.nb) begin
          n_fail++;
          $display("FAIL word: got data=%h last=%0b nbytes=%0d, required data=%h last=%0b nbytes=%0d",
                   out_data, out_last, out_nbytes, e.d, e.l, e.nb);
        end
      end
    end
    if (rst === 1'b1 && flush_done === 1'b1) got_flushes++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic send(input bit v, input logic [24:0] b, input logic [4:0] l, input bit f);
    int k;
    k = 0;
    @(negedge clk);
    in_valid = v;
    in_bits  = b;
    in_len   = l;
    flush    = f;
    while (in_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (in_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=%b, required 1 within 200 cycles", in_ready);
    end else begin
      model(v, b, l, f);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic settle(input int cyc);
    int k;
    k = 0;
    while ((expq.size() != 0 || out_valid === 1'b1) && k < cyc) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit v, f;
    rst = 1'b0;
    in_valid = 1'b0;
    in_bits = '0;
    in_len = '0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out_valid",  32'(out_valid), 32'd0);
    check("reset_out_data",   out_data, 32'd0);
    check("reset_out_last",   32'(out_last), 32'd0);
    check("reset_out_nbytes", 32'(out_nbytes), 32'd0);
    check("reset_flush_done", 32'(flush_done), 32'd0);
    check("reset_in_ready",   32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", 32'(in_ready), 32'd1);

    // T1: two codes form exactly one word
    send(1, 25'h0007EE6, 5'd15, 0);
    send(1, 25'h001FFFF, 5'd17, 0);
    settle(50);

    // T2: two zero bits then flush
    send(1, 25'h0, 5'd2, 0);
    send(0, 25'h0, 5'd0, 1);
    settle(50);

    // T3: back-pressure with three 25-bit codes
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    send(1, 25'h1FFFFFF, 5'd25, 0);
    send(1, 25'h1FFFFFF, 5'd25, 0);
    send(1, 25'h1FFFFFF, 5'd25, 0);
    repeat (3) @(negedge clk);
    check("t3_stall_in_ready", 32'(in_ready), 32'd0);
    check("t3_stall_valid", 32'(out_valid), 32'd1);
    check("t3_stall_data", out_data, 32'hFFFFFFFF);
    repeat (2) @(negedge clk);
    check("t3_hold_data", out_data, 32'hFFFFFFFF);
    rdy_mode = 1;
    send(0, 25'h0, 5'd0, 1);
    settle(50);

    // T4: empty flush, then 3-bit code plus zero-length code
    send(0, 25'h0, 5'd0, 1);
    settle(20);
    send(1, 25'h5, 5'd3, 0);
    send(1, 25'h1ABCDEF, 5'd0, 0);
    send(0, 25'h0, 5'd0, 1);
    settle(50);

    // T6: oversize length clamps to 25
    send(1, 25'h1FFFFFF, 5'd31, 0);
    send(0, 25'h0, 5'd0, 1);
    settle(50);

    // T5: asynchronous reset with a held word and 20 pending bits
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    send(1, 25'h1234567, 5'd25, 0);
    send(1, 25'h55, 5'd7, 0);
    send(1, 25'hABCDE, 5'd20, 0);
    #3;
    rst = 1'b0;
    #1;
    check("t5_async_out_valid",  32'(out_valid), 32'd0);
    check("t5_async_out_data",   out_data, 32'd0);
    check("t5_async_out_last",   32'(out_last), 32'd0);
    check("t5_async_out_nbytes", 32'(out_nbytes), 32'd0);
    check("t5_async_in_ready",   32'(in_ready), 32'd0);
    expq.delete();
    bitq.delete();
    @(negedge clk);
    rst = 1'b1;
    rdy_mode = 1;
    @(negedge clk);
    check("t5_release_in_ready", 32'(in_ready), 32'd1);
    send(0, 25'h0, 5'd0, 1);
    settle(50);

    // Random traffic with random back-pressure
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 7) != 0);
      f = ($urandom_range(0, 11) == 0);
      if (!v && !f) v = 1'b1;
      send(v, 25'($urandom), 5'($urandom_range(0, 31)), f);
    end
    send(0, 25'h0, 5'd0, 1);
    rdy_mode = 1;
    settle(500);

    check("pending_words", 32'(expq.size()), 32'd0);
    check("flush_done_count", 32'(got_flushes), 32'(exp_flushes));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
